// File: rtl/seg_scan_capture.sv
// Captures a multiplexed, active-low 7-segment display scan into four decoded digit codes.
// Every pin is registered once (S); a pattern is evaluated only after it has been stable for STABLE_CYCLES.
module seg_scan_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    input  logic        e,
    input  logic        f,
    input  logic        g,
    input  logic        dp,
    input  logic [3:0]  pos,
    output logic [15:0] digits,
    output logic [3:0]  dps,
    output logic        frame_done,
    output logic        seg_err,
    output logic        pos_err,
    output logic        stuck,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        CAPT = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [3:0]  STABLE_MAX  = 4'(STABLE_CYCLES);
    localparam logic [15:0] TIMEOUT_MAX = 16'(TIMEOUT);

    state_t      state, state_next;
    logic [11:0] s_q;      // {pos, a..g, dp}
    logic [11:0] s_prev;
    logic [3:0]  cnt, cnt_next;
    logic [15:0] tcnt;
    logic [3:0]  seen, seen_next;

    logic        change;
    logic        pos_change;
    logic        capture;
    logic [3:0]  s_pos;
    logic [6:0]  s_seg;
    logic        s_dp;
    logic        pos_legal;
    logic        pos_blank;
    logic [1:0]  idx;
    logic [4:0]  dec;

    function automatic logic [4:0] decode(input logic [6:0] segs);
        // Returns {legal, code}
        case (segs)
            7'b0000001: decode = 5'h10;
            7'b1001111: decode = 5'h11;
            7'b0010010: decode = 5'h12;
            7'b0000110: decode = 5'h13;
            7'b1001100: decode = 5'h14;
            7'b0100100: decode = 5'h15;
            7'b0100000: decode = 5'h16;
            7'b0001111: decode = 5'h17;
            7'b0000000: decode = 5'h18;
            7'b0000100: decode = 5'h19;
            7'b1111111: decode = 5'h1F;
            default:    decode = 5'h00;
        endcase
    endfunction

    assign s_pos      = s_q[11:8];
    assign s_seg      = s_q[7:1];
    assign s_dp       = s_q[0];
    assign change     = (s_q != s_prev);
    assign pos_change = (s_q[11:8] != s_prev[11:8]);
    assign dec        = decode(s_seg);
    assign pos_blank  = (s_pos == 4'b1111);
    assign stuck      = (tcnt == TIMEOUT_MAX);
    assign fsm_state  = state;

    always_comb begin
        pos_legal = 1'b1;
        idx       = 2'd0;
        case (s_pos)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: pos_legal = 1'b0;
        endcase
    end

    always_comb begin
        cnt_next = cnt;
        if (change)
            cnt_next = 4'd1;
        else if (cnt != STABLE_MAX)
            cnt_next = cnt + 4'd1;
    end

    // Evaluation happens on the edge that enters CAPT, so results are visible during CAPT.
    assign capture = (state == WAIT) && (cnt_next == STABLE_MAX);

    always_comb begin
        state_next = state;
        case (state)
            WAIT:    if (capture) state_next = CAPT;
            CAPT:    state_next = change ? WAIT : HOLD;
            HOLD:    if (change) state_next = WAIT;
            default: state_next = WAIT;
        endcase
    end

    always_comb begin
        seen_next = (seen == 4'b1111) ? 4'b0000 : seen;
        if (capture && pos_legal && dec[4])
            seen_next[idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= WAIT;
            s_q    <= '1;
            s_prev <= '1;
            cnt    <= '0;
            tcnt   <= '0;
            seen   <= '0;
        end else begin
            state  <= state_next;
            s_q    <= {pos, a, b, c, d, e, f, g, dp};
            s_prev <= s_q;
            cnt    <= cnt_next;
            seen   <= seen_next;
            if (pos_change)
                tcnt <= '0;
            else if (tcnt != TIMEOUT_MAX)
                tcnt <= tcnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            digits     <= 16'hFFFF;
            dps        <= 4'b0000;
            frame_done <= 1'b0;
            seg_err    <= 1'b0;
            pos_err    <= 1'b0;
        end else begin
            frame_done <= (seen == 4'b1111);
            seg_err    <= 1'b0;
            pos_err    <= 1'b0;
            if (capture) begin
                if (pos_legal) begin
                    if (dec[4]) begin
                        digits[{idx, 2'b00} +: 4] <= dec[3:0];
                        dps[idx]                  <= ~s_dp;
                    end else begin
                        seg_err <= 1'b1;
                    end
                end else if (!pos_blank) begin
                    pos_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: scans digits through the pins and checks captures, pulses and timeout.
module tb_seg_scan_capture;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 40;

    logic        clk;
    logic        reset;
    logic [6:0]  segs_drv;
    logic        dp;
    logic [3:0]  pos;
    logic [15:0] digits;
    logic [3:0]  dps;
    logic        frame_done;
    logic        seg_err;
    logic        pos_err;
    logic        stuck;
    logic [1:0]  fsm_state;

    int n_checks = 0;
    int n_fail   = 0;
    int fd_cnt   = 0;
    int se_cnt   = 0;
    int pe_cnt   = 0;

    seg_scan_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .a(segs_drv[6]), .b(segs_drv[5]), .c(segs_drv[4]), .d(segs_drv[3]),
        .e(segs_drv[2]), .f(segs_drv[1]), .g(segs_drv[0]),
        .dp(dp), .pos(pos),
        .digits(digits), .dps(dps), .frame_done(frame_done),
        .seg_err(seg_err), .pos_err(pos_err), .stuck(stuck), .fsm_state(fsm_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] seg_of(input int code);
        case (code)
            0: seg_of = 7'b0000001;
            1: seg_of = 7'b1001111;
            2: seg_of = 7'b0010010;
            3: seg_of = 7'b0000110;
            4: seg_of = 7'b1001100;
            5: seg_of = 7'b0100100;
            6: seg_of = 7'b0100000;
            7: seg_of = 7'b0001111;
            8: seg_of = 7'b0000000;
            9: seg_of = 7'b0000100;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    // One clock; outputs are sampled 1ns after the rising edge and pulses are tallied.
    task automatic step();
        @(posedge clk);
        #1;
        if (frame_done) fd_cnt++;
        if (seg_err)    se_cnt++;
        if (pos_err)    pe_cnt++;
    endtask

    task automatic scan_raw(input logic [3:0] p, input logic [6:0] s, input logic dpn, input int hold);
        pos      = p;
        segs_drv = s;
        dp       = dpn;
        repeat (hold) step();
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        pos      = 4'b1111;
        segs_drv = 7'b1111111;
        dp       = 1'b1;
        repeat (3) step();
        reset = 1'b1;
        repeat (6) step();
        fd_cnt = 0;
        se_cnt = 0;
        pe_cnt = 0;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        pos      = 4'b1110;
        segs_drv = seg_of(8);
        dp       = 1'b0;
        repeat (8) step();
        n_checks++; if (digits !== 16'hFFFF) begin n_fail++; $display("FAIL reset_digits: got %h expected ffff", digits); end
        n_checks++; if (dps !== 4'b0000) begin n_fail++; $display("FAIL reset_dps: got %b expected 0000", dps); end
        n_checks++; if ({frame_done, seg_err, pos_err} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b expected 000", {frame_done, seg_err, pos_err}); end
        n_checks++; if (stuck !== 1'b0) begin n_fail++; $display("FAIL reset_stuck: got %b expected 0", stuck); end
        n_checks++; if (fsm_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", fsm_state); end
    endtask

    // Pin change to digits update takes STABLE+1 edges.
    task automatic test_latency();
        do_reset();
        pos      = 4'b1110;
        segs_drv = seg_of(5);
        dp       = 1'b1;
        repeat (STABLE) step();
        n_checks++; if (digits[3:0] !== 4'hF) begin n_fail++; $display("FAIL latency_early: got %h expected f", digits[3:0]); end
        step();
        n_checks++; if (digits[3:0] !== 4'h5) begin n_fail++; $display("FAIL latency_edge: got %h expected 5", digits[3:0]); end
        n_checks++; if (fsm_state !== 2'd1) begin n_fail++; $display("FAIL latency_capt_state: got %0d expected 1", fsm_state); end
    endtask

    task automatic test_scan_3210();
        do_reset();
        scan_raw(4'b1110, seg_of(0), 1'b1, 8);
        scan_raw(4'b1101, seg_of(1), 1'b1, 8);
        scan_raw(4'b1011, seg_of(2), 1'b1, 8);
        n_checks++; if (fd_cnt !== 0) begin n_fail++; $display("FAIL scan_partial_frame: got %0d expected 0", fd_cnt); end
        scan_raw(4'b0111, seg_of(3), 1'b1, 8);
        n_checks++; if (digits !== 16'h3210) begin n_fail++; $display("FAIL scan_digits: got %h expected 3210", digits); end
        n_checks++; if (dps !== 4'b0000) begin n_fail++; $display("FAIL scan_dps: got %b expected 0000", dps); end
        n_checks++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL scan_frame1: got %0d expected 1", fd_cnt); end
        scan_raw(4'b1110, seg_of(0), 1'b1, 8);
        scan_raw(4'b1101, seg_of(1), 1'b1, 8);
        scan_raw(4'b1011, seg_of(2), 1'b1, 8);
        scan_raw(4'b0111, seg_of(3), 1'b1, 8);
        n_checks++; if (fd_cnt !== 2) begin n_fail++; $display("FAIL scan_frame2: got %0d expected 2", fd_cnt); end
        n_checks++; if (se_cnt + pe_cnt !== 0) begin n_fail++; $display("FAIL scan_errors: got %0d expected 0", se_cnt + pe_cnt); end
    endtask

    task automatic test_short_digit();
        do_reset();
        scan_raw(4'b1110, seg_of(0), 1'b1, 8);
        scan_raw(4'b1101, seg_of(1), 1'b1, 3);
        scan_raw(4'b1011, seg_of(2), 1'b1, 8);
        scan_raw(4'b0111, seg_of(3), 1'b1, 8);
        n_checks++; if (digits !== 16'h32F0) begin n_fail++; $display("FAIL short_digits: got %h expected 32f0", digits); end
        n_checks++; if (fd_cnt !== 0) begin n_fail++; $display("FAIL short_frame: got %0d expected 0", fd_cnt); end
        scan_raw(4'b1101, seg_of(1), 1'b1, 8);
        n_checks++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL short_completed_frame: got %0d expected 1", fd_cnt); end
        n_checks++; if (digits !== 16'h3210) begin n_fail++; $display("FAIL short_final_digits: got %h expected 3210", digits); end
    endtask

    task automatic test_seg_err();
        do_reset();
        scan_raw(4'b1011, seg_of(7), 1'b1, 8);
        scan_raw(4'b1011, 7'b1010101, 1'b1, 6);
        scan_raw(4'b1111, seg_of(8), 1'b1, 8);
        n_checks++; if (se_cnt !== 1) begin n_fail++; $display("FAIL seg_err_count: got %0d expected 1", se_cnt); end
        n_checks++; if (digits[11:8] !== 4'h7) begin n_fail++; $display("FAIL seg_err_slice: got %h expected 7", digits[11:8]); end
        n_checks++; if (pe_cnt !== 0) begin n_fail++; $display("FAIL seg_err_pos_err: got %0d expected 0", pe_cnt); end
    endtask

    task automatic test_pos_err();
        do_reset();
        scan_raw(4'b1100, seg_of(8), 1'b1, 6);
        n_checks++; if (pe_cnt !== 1) begin n_fail++; $display("FAIL pos_err_count: got %0d expected 1", pe_cnt); end
        scan_raw(4'b1111, 7'b1010101, 1'b1, 8);
        n_checks++; if (pe_cnt !== 1) begin n_fail++; $display("FAIL pos_blank_no_err: got %0d expected 1", pe_cnt); end
        n_checks++; if (se_cnt !== 0) begin n_fail++; $display("FAIL pos_blank_seg_err: got %0d expected 0", se_cnt); end
        n_checks++; if (digits !== 16'hFFFF) begin n_fail++; $display("FAIL pos_err_digits: got %h expected ffff", digits); end
    endtask

    // The pos change reaches S on edge 1 and clears the counter on edge 2; stuck follows TIMEOUT edges later.
    task automatic test_timeout();
        do_reset();
        pos      = 4'b1110;
        segs_drv = seg_of(0);
        dp       = 1'b1;
        repeat (TIMEOUT + 1) step();
        n_checks++; if (stuck !== 1'b0) begin n_fail++; $display("FAIL stuck_early: got %b expected 0", stuck); end
        step();
        n_checks++; if (stuck !== 1'b1) begin n_fail++; $display("FAIL stuck_rise: got %b expected 1", stuck); end
        repeat (5) step();
        n_checks++; if (stuck !== 1'b1) begin n_fail++; $display("FAIL stuck_hold: got %b expected 1", stuck); end
        pos = 4'b1101;
        step();
        n_checks++; if (stuck !== 1'b1) begin n_fail++; $display("FAIL stuck_s_edge: got %b expected 1", stuck); end
        step();
        n_checks++; if (stuck !== 1'b0) begin n_fail++; $display("FAIL stuck_fall: got %b expected 0", stuck); end
    endtask

    task automatic test_reset_mid_capture();
        do_reset();
        scan_raw(4'b1110, seg_of(0), 1'b1, 8);
        scan_raw(4'b1101, seg_of(1), 1'b1, 8);
        scan_raw(4'b1011, seg_of(2), 1'b0, STABLE + 1);
        n_checks++; if (fsm_state !== 2'd1) begin n_fail++; $display("FAIL mid_in_capt: got %0d expected 1", fsm_state); end
        n_checks++; if (dps !== 4'b0100) begin n_fail++; $display("FAIL mid_dp_capture: got %b expected 0100", dps); end
        reset = 1'b0;
        step();
        n_checks++; if (digits !== 16'hFFFF) begin n_fail++; $display("FAIL mid_reset_digits: got %h expected ffff", digits); end
        n_checks++; if (dps !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_dps: got %b expected 0000", dps); end
        n_checks++; if (fsm_state !== 2'd0) begin n_fail++; $display("FAIL mid_reset_state: got %0d expected 0", fsm_state); end
        reset  = 1'b1;
        fd_cnt = 0;
        repeat (8) step();
        scan_raw(4'b0111, seg_of(3), 1'b1, 8);
        n_checks++; if (fd_cnt !== 0) begin n_fail++; $display("FAIL mid_no_early_frame: got %0d expected 0", fd_cnt); end
        scan_raw(4'b1110, seg_of(0), 1'b1, 8);
        scan_raw(4'b1101, seg_of(1), 1'b1, 8);
        n_checks++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL mid_frame_after_rescan: got %0d expected 1", fd_cnt); end
        n_checks++; if (digits !== 16'h3210) begin n_fail++; $display("FAIL mid_rescan_digits: got %h expected 3210", digits); end
    endtask

    task automatic test_recapture();
        do_reset();
        scan_raw(4'b1110, seg_of(0), 1'b1, 8);
        scan_raw(4'b1101, seg_of(1), 1'b1, 8);
        scan_raw(4'b1110, seg_of(5), 1'b1, 8);
        scan_raw(4'b1011, seg_of(9), 1'b0, 8);
        n_checks++; if (fd_cnt !== 0) begin n_fail++; $display("FAIL recap_no_frame: got %0d expected 0", fd_cnt); end
        scan_raw(4'b0111, seg_of(6), 1'b1, 8);
        n_checks++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL recap_frame: got %0d expected 1", fd_cnt); end
        n_checks++; if (digits !== 16'h6915) begin n_fail++; $display("FAIL recap_digits: got %h expected 6915", digits); end
        n_checks++; if (dps !== 4'b0100) begin n_fail++; $display("FAIL recap_dps: got %b expected 0100", dps); end
        scan_raw(4'b1111, seg_of(8), 1'b1, 8);
        n_checks++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL recap_single_pulse: got %0d expected 1", fd_cnt); end
    endtask

    initial begin
        reset    = 1'b0;
        pos      = 4'b1111;
        segs_drv = 7'b1111111;
        dp       = 1'b1;
        test_reset();
        test_latency();
        test_scan_3210();
        test_short_digit();
        test_seg_err();
        test_pos_err();
        test_timeout();
        test_reset_mid_capture();
        test_recapture();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
